// File: rtl/point_mult_ctrl_pkg.sv
// Shared widths, curve constants, FSM encoding and point payload for the point multiplier.
package point_mult_ctrl_pkg;

  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = $clog2(DW);
  localparam int unsigned FIELD_P = 17;
  localparam int unsigned CURVE_A = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOUBLE = 2'd1,
    ADD    = 2'd2,
    FIN    = 2'd3
  } state_e;

  // Affine point; (0,0) encodes the point at infinity.
  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } point_t;

endpackage

// File: rtl/point_mult_ctrl_point_adder.sv
// Combinational affine point adder over GF(FIELD_P); handles P+Q and P+P.
module point_mult_ctrl_point_adder
  import point_mult_ctrl_pkg::*;
(
  input  point_t p,
  input  point_t q,
  output point_t sum_c
);

  localparam int unsigned PW = 2 * DW;

  function automatic logic [DW-1:0] f_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = (DW+1)'(a) + (DW+1)'(b);
    return DW'(s % (DW+1)'(FIELD_P));
  endfunction

  function automatic logic [DW-1:0] f_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] nb;
    nb = (b == '0) ? '0 : DW'(FIELD_P) - b;
    return f_add(a, nb);
  endfunction

  function automatic logic [DW-1:0] f_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] prod;
    prod = PW'(a) * PW'(b);
    return DW'(prod % PW'(FIELD_P));
  endfunction

  // Fermat inverse a^(p-2); inverse of 0 is never requested.
  function automatic logic [DW-1:0] f_inv(input logic [DW-1:0] a);
    logic [DW-1:0] e;
    logic [DW-1:0] res;
    logic [DW-1:0] base;
    e    = DW'(FIELD_P - 2);
    res  = DW'(1);
    base = a;
    for (int i = 0; i < int'(DW); i++) begin
      if (e[i]) res = f_mul(res, base);
      base = f_mul(base, base);
    end
    return res;
  endfunction

  logic          p_inf;
  logic          q_inf;
  logic [DW-1:0] lambda;
  logic [DW-1:0] x3;
  logic [DW-1:0] y3;

  assign p_inf = (p.x == '0) && (p.y == '0);
  assign q_inf = (q.x == '0) && (q.y == '0);

  // Chord/tangent selection with infinity and inverse-point short cuts.
  always_comb begin
    lambda = '0;
    x3     = '0;
    y3     = '0;
    sum_c  = '0;
    if (p_inf) begin
      sum_c = q;
    end else if (q_inf) begin
      sum_c = p;
    end else if ((p.x == q.x) && (f_add(p.y, q.y) == '0)) begin
      sum_c = '0;
    end else begin
      if (p.x == q.x)
        lambda = f_mul(f_add(f_mul(DW'(3), f_mul(p.x, p.x)), DW'(CURVE_A)),
                       f_inv(f_add(p.y, p.y)));
      else
        lambda = f_mul(f_sub(q.y, p.y), f_inv(f_sub(q.x, p.x)));
      x3    = f_sub(f_sub(f_mul(lambda, lambda), p.x), q.x);
      y3    = f_sub(f_mul(lambda, f_sub(p.x, x3)), p.y);
      sum_c = '{x: x3, y: y3};
    end
  end

endmodule

// File: rtl/point_mult_ctrl.sv
// MSB-first double-and-add controller computing R = k*P with one shared point adder.
module point_mult_ctrl
  import point_mult_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] k,
  input  logic [DW-1:0] Px,
  input  logic [DW-1:0] Py,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Rx,
  output logic [DW-1:0] Ry
);

  state_e        state;
  logic [CW-1:0] idx;
  logic [DW-1:0] k_q;
  point_t        p_q;
  point_t        r_q;
  point_t        add_q;
  point_t        add_sum;

  // Adder second operand: R when doubling, P when adding.
  assign add_q = (state == ADD) ? p_q : r_q;

  point_mult_ctrl_point_adder u_adder (
    .p     (r_q),
    .q     (add_q),
    .sum_c (add_sum)
  );

  assign Rx = r_q.x;
  assign Ry = r_q.y;

  // Sequencer: one adder step per cycle, busy/done registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      k_q   <= '0;
      p_q   <= '0;
      r_q   <= '0;
      idx   <= CW'(DW - 1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q   <= k;
            p_q   <= '{x: Px, y: Py};
            r_q   <= '0;
            idx   <= CW'(DW - 1);
            state <= DOUBLE;
            busy  <= 1'b1;
          end
        end
        DOUBLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            r_q <= add_sum;
            if (k_q[idx]) begin
              state <= ADD;
            end else if (idx == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx <= idx - CW'(1);
            end
          end
        end
        ADD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            r_q <= add_sum;
            if (idx == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx   <= idx - CW'(1);
              state <= DOUBLE;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_mult_ctrl.sv
// Randomized self-checking bench for point_mult_ctrl against a repeated-addition model.
module tb_point_mult_ctrl;
  import point_mult_ctrl_pkg::*;

  localparam int MODP = 17;

  typedef struct packed {
    int x;
    int y;
  } pt_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] k;
  logic [DW-1:0] Px;
  logic [DW-1:0] Py;
  logic          busy;
  logic          done;
  logic [DW-1:0] Rx;
  logic [DW-1:0] Ry;

  int n_checks = 0;
  int n_fail   = 0;
  int cx[$];
  int cy[$];

  point_mult_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .k     (k),
    .Px    (Px),
    .Py    (Py),
    .busy  (busy),
    .done  (done),
    .Rx    (Rx),
    .Ry    (Ry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field inverse by exhaustive search.
  function automatic int m_inv(input int a);
    for (int x = 1; x < MODP; x++)
      if ((a * x) % MODP == 1) return x;
    return 0;
  endfunction

  // Textbook affine addition on y^2 = x^3 + 2x + 2 mod 17.
  function automatic pt_t m_add(input pt_t a, input pt_t b);
    int l;
    pt_t r;
    if (a.x == 0 && a.y == 0) return b;
    if (b.x == 0 && b.y == 0) return a;
    if (a.x == b.x && (a.y + b.y) % MODP == 0) return '{x: 0, y: 0};
    if (a.x == b.x)
      l = ((3 * a.x * a.x + 2) % MODP) * m_inv((2 * a.y) % MODP) % MODP;
    else
      l = ((b.y - a.y + MODP) % MODP) * m_inv((b.x - a.x + MODP) % MODP) % MODP;
    r.x = (l * l - a.x - b.x + 2 * MODP) % MODP;
    r.y = (l * ((a.x - r.x + MODP) % MODP) - a.y + MODP) % MODP;
    return r;
  endfunction

  // k*P as k repeated additions.
  function automatic pt_t m_mult(input int kk, input pt_t p);
    pt_t r;
    r = '{x: 0, y: 0};
    for (int i = 0; i < kk; i++) r = m_add(r, p);
    return r;
  endfunction

  // Launch one operation and follow it to done, abort or reset.
  task automatic run_op(input logic [DW-1:0] kk, input logic [DW-1:0] px, input logic [DW-1:0] py,
                        input bit keep_start, input bit mid_start, input int kill_at, input bit kill_rst);
    pt_t expv;
    int  lat;
    int  n;
    int  busy_cnt;
    int  done_seen;
    bit  found;
    bit  got_done;
    expv  = m_mult(int'(kk), '{x: int'(px), y: int'(py)});
    lat   = int'(DW) + $countones(kk);
    k     = kk;
    Px    = px;
    Py    = py;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (busy) found = 1'b1;
    end
    check("accept", 32'(found), 32'd1);
    if (!keep_start) start = 1'b0;
    n        = 0;
    busy_cnt = 1;
    got_done = 1'b0;
    while (n < 64 && !got_done) begin
      if (mid_start && n == 2) begin
        start = 1'b1;
        k     = ~kk;
        Px    = 8'd6;
        Py    = 8'd3;
      end
      if (mid_start && n == 4) start = 1'b0;
      if (kill_at > 0 && n == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else abort = 1'b1;
      end
      tick();
      n++;
      if (kill_at > 0 && n == kill_at + 1) begin
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_done", 32'(done), 32'd0);
        if (kill_rst) begin
          check("rst_rx", 32'(Rx), 32'd0);
          check("rst_ry", 32'(Ry), 32'd0);
        end
        rst       = 1'b0;
        abort     = 1'b0;
        done_seen = 0;
        repeat (4) begin
          tick();
          if (done) done_seen++;
        end
        check("kill_no_done", 32'(done_seen), 32'd0);
        return;
      end
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
    end
    check("latency", 32'(n), 32'(lat));
    check("rx", 32'(Rx), 32'(expv.x));
    check("ry", 32'(Ry), 32'(expv.y));
    check("busy_cycles", 32'(busy_cnt), 32'(lat + 1));
    if (!keep_start) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("hold_rx", 32'(Rx), 32'(expv.x));
    end
  endtask

  initial begin
    int sel;
    logic [DW-1:0] rk;
    logic [DW-1:0] rx;
    logic [DW-1:0] ry;
    for (int x = 0; x < MODP; x++)
      for (int y = 0; y < MODP; y++)
        if ((y * y) % MODP == (x * x * x + 2 * x + 2) % MODP) begin
          cx.push_back(x);
          cy.push_back(y);
        end

    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    k     = 8'd3;
    Px    = 8'd5;
    Py    = 8'd1;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rx", 32'(Rx), 32'd0);
    check("reset_ry", 32'(Ry), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    tick();

    run_op(8'd1, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'd3, 8'd5, 8'd1, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'd2, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'd19, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'd18, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'd0, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'd0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'd7, 8'd5, 8'd1, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'hA5, 8'd5, 8'd1, 1'b0, 1'b0, 4, 1'b0);
    run_op(8'd5, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hC0, 8'd5, 8'd1, 1'b0, 1'b0, 3, 1'b1);
    run_op(8'd3, 8'd5, 8'd1, 1'b0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      rk  = 8'($urandom);
      sel = int'($urandom_range(0, cx.size()));
      if (sel == cx.size()) begin
        rx = 8'd0;
        ry = 8'd0;
      end else begin
        rx = 8'(cx[sel]);
        ry = 8'(cy[sel]);
      end
      run_op(rk, rx, ry, 1'b0, (t % 3) == 1, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/point_mult_ctrl.md
Name: point_mult_ctrl

Overview:
- Sequential controller that computes the scalar multiple R = k·P on the elliptic curve.
- Uses MSB-first double-and-add.
- Time-shares one combinational PointAdder instance for both doubling (R+R) and adding (R+P).
- Sits between the key/encryption control logic and the point arithmetic. All field arithmetic stays inside PointAdder.
- The point at infinity is encoded as (0,0) everywhere.

Parameters:
- DW, `DATAWIDTH, width of coordinates and of the scalar.
- CW, $clog2(`DATAWIDTH), width of the bit-index counter.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiplication; honoured only in IDLE.
- abort  input  1  cancel the running operation; return to IDLE without done.
- k  input  DW  scalar; sampled when start is accepted.
- Px  input  DW  base point x; sampled when start is accepted.
- Py  input  DW  base point y; sampled when start is accepted.
- busy  output  1  high in DOUBLE, ADD and FIN.
- done  output  1  one-cycle pulse when Rx/Ry are valid.
- Rx  output  DW  result x; holds until the next accepted start.
- Ry  output  DW  result y; holds until the next accepted start.

Behaviour:
- Reset:
  - state=IDLE, busy=0, done=0.
  - Rx=Ry=0, internal k/P registers=0, idx=DW-1.
  - Reset overrides start and abort in the same cycle.
- IDLE:
  - On start=1: latch k, Px, Py; set R=(0,0), idx=DW-1; go to DOUBLE.
  - start=0: stay.
- DOUBLE:
  - Adder operands = (R,R); R <= adder result.
  - If k[idx]=1: go to ADD.
  - Else if idx=0: go to FIN.
  - Else: idx <= idx-1, stay in DOUBLE.
- ADD:
  - Adder operands = (R,P); R <= adder result.
  - If idx=0: go to FIN.
  - Else: idx <= idx-1, go to DOUBLE.
- FIN:
  - done=1 for exactly this cycle; Rx/Ry present the final R; go to IDLE.
- Rx/Ry are the R register itself:
  - They change during computation.
  - They are guaranteed valid only in the done cycle and afterwards until the next accepted start.
- Operand mux:
  - Single 2:1 select on the adder Q-input (R in DOUBLE, P in ADD). The P-input is always R.
  - The adder is purely combinational; each step is one cycle.
- Latency:
  - With start accepted at edge T0, done is high in the cycle after edge T0 + DW + popcount(k).
  - In cycles after start: DW + popcount(k) + 1.
  - No early-out on leading zeros; doubling (0,0) yields (0,0).
- start while busy: ignored, with no effect on latched operands.
- abort:
  - Effective in DOUBLE or ADD: next state IDLE, no done pulse.
  - Rx/Ry are left at the partial value and are not to be used.
  - Ignored in IDLE and FIN.
- Boundary cases:
  - k=0 → result (0,0).
  - P=(0,0) → result (0,0).
  - A doubling of a point with y=0, or an R+P with R = -P, yields (0,0) via the adder's inverse check. The controller needs no special case.
- Scalar width: k is interpreted unsigned, full DW bits. No reduction modulo the curve order is performed.

Decomposition:
- Shared header parameters.vh (existing) supplies `DATAWIDTH, the field prime and `A.
- Add state encodings as localparams in the same header: IDLE=2'd0, DOUBLE=2'd1, ADD=2'd2, FIN=2'd3.
- One sub-module: an instance of the existing PointAdder.
- The controller contains only the FSM, idx counter, operand mux and registers; no field arithmetic.

Test Plan:
Bench curve: parameters.vh with DW=8, y²=x³+2x+2 mod 17, `A=2, G=(5,1), order 19.
- k=1, P=G → done exactly 10 cycles after the start edge; (Rx,Ry)=(5,1); busy high 9+1 cycles.
- k=3 → (10,6), done at cycle 11. Then k=2 → (6,3), done at cycle 10. Checks back-to-back starts with start held high across the done cycle.
- k=19 → (0,0) (point at infinity). k=18 → (5,16). k=0 → (0,0), done at cycle 9.
- P=(0,0), k=0xFF → (0,0), done at cycle 17.
- start pulsed again mid-operation with different k/P → ignored; the original result still delivered. abort in cycle 4 → busy drops next cycle, no done; a new start then computes k=5 → (9,16).
- rst asserted in an ADD cycle → next cycle IDLE, busy=0, done=0, Rx=Ry=0; a subsequent start runs normally.
